bus_requester: RTL and testbench

//  Client-side master for the two-wire req/gnt arbitration interface.
//  A start pulse queues a burst of LEN words; the block raises req and waits for gnt.

---
 rtl/bus_requester.sv | 88 ++++++++
 tb/tb_bus_requester.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_requester.sv
// bus_requester: req/gnt burst master emitting len incrementing words per grant
module bus_requester #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] seed,
  input  logic              gnt,
  output logic              req,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              done,
  output logic              timeout_err
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] XFER    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;
  localparam int WAIT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              done_q, done_d, terr_q, terr_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    terr_d  = 1'b0;
    case (state_q)
      IDLE:
        if (start && len != '0) begin
          state_d = REQ;
          cnt_d   = len;
          data_d  = seed;
          wait_d  = '0;
        end
      REQ:
        if (gnt) state_d = XFER;
        else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
          state_d = RELEASE;
          terr_d  = 1'b1;
        end else wait_d = wait_q + WAIT_W'(1);
      XFER:
        if (gnt) begin
          data_d = data_q + DATA_W'(1);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = RELEASE;
            done_d  = 1'b1;
          end
        end
      default:
        if (!gnt) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  // RELEASE keeps req low until the arbiter's registered grant has cleared
  assign req         = state_q == REQ || state_q == XFER;
  assign busy        = state_q != IDLE;
  assign data_valid  = state_q == XFER && gnt;
  assign data_out    = data_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_bus_requester.sv
// tb_bus_requester: scoreboard bench for the req/gnt burst master
module tb_bus_requester;
  logic       clk = 0, rst = 1, start = 0, gnt = 0;
  logic [3:0] len = 0;
  logic [7:0] seed = 0;
  logic       req, busy, data_valid, done, timeout_err;
  logic [7:0] data_out, e;
  int tests = 0, fails = 0, beats = 0, dones = 0, touts = 0;
  logic [7:0] exp_q[$];
  bus_requester dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .seed(seed), .gnt(gnt),
    .req(req), .busy(busy), .data_out(data_out), .data_valid(data_valid),
    .done(done), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst) begin
    if (data_valid) begin
      tests++;
      beats++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected got=%h required=none", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          fails++;
          $display("FAIL beat_data got=%h required=%h", data_out, e);
        end
      end
    end
    if (done) dones++;
    if (timeout_err) touts++;
    if (done || timeout_err) begin
      tests++;
      if (done && timeout_err) begin
        fails++;
        $display("FAIL done_terr_exclusive got=11 required=not both");
      end
    end
  end
  task automatic start_burst(input logic [3:0] l, input logic [7:0] s, input bit push);
    @(posedge clk); #1;
    start = 1; len = l; seed = s;
    if (push) for (int i = 0; i < int'(l); i++) exp_q.push_back(s + 8'(i));
    @(posedge clk); #1;
    start = 0; len = 0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    tests++;
    if ({req, busy, data_valid, done, timeout_err} !== 5'b0 || data_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_state got=%b/%h required=00000/00", {req, busy, data_valid, done, timeout_err}, data_out);
    end
    @(posedge clk); #1 rst = 0;
  endtask
  task automatic test_basic;
    int d0;
    d0 = dones;
    start_burst(4'd3, 8'hA0, 1);
    @(negedge clk);
    tests++;
    if (req !== 1 || busy !== 1 || data_valid !== 0) begin
      fails++;
      $display("FAIL basic_req got=%b%b%b required=110", req, busy, data_valid);
    end
    @(posedge clk); #1;
    @(posedge clk); #1 gnt = 1;
    @(negedge clk);
    tests++;
    if (data_valid !== 0) begin fails++; $display("FAIL basic_grant_lag got=%b required=0", data_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (data_valid !== 1) begin fails++; $display("FAIL basic_beat%0d got=%b required=1", i, data_valid); end
    end
    @(negedge clk);
    tests++;
    if (done !== 1 || req !== 0 || data_valid !== 0 || busy !== 1) begin
      fails++;
      $display("FAIL basic_done got=%b%b%b%b required=1001", done, req, data_valid, busy);
    end
    @(posedge clk); #1 gnt = 0;
    @(negedge clk);
    tests++;
    if (done !== 0 || busy !== 1 || req !== 0) begin fails++; $display("FAIL basic_release got=%b%b%b required=010", done, busy, req); end
    @(negedge clk);
    tests++;
    if (busy !== 0 || exp_q.size() != 0 || dones - d0 != 1) begin
      fails++;
      $display("FAIL basic_idle got=busy%b left%0d dones%0d required=busy0 left0 dones1", busy, exp_q.size(), dones - d0);
    end
  endtask
  task automatic test_pause;
    int d0;
    d0 = dones;
    start_burst(4'd4, 8'h10, 1);
    gnt = 1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 gnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (req !== 1 || data_valid !== 0 || busy !== 1 || data_out !== 8'h12) begin
        fails++;
        $display("FAIL pause%0d got=%b%b%b/%h required=101/12", i, req, data_valid, busy, data_out);
      end
    end
    @(posedge clk); #1 gnt = 1;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    tests++;
    if (done !== 1 || req !== 0) begin fails++; $display("FAIL pause_done got=%b%b required=10", done, req); end
    @(posedge clk); #1 gnt = 0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    tests++;
    if (busy !== 0 || exp_q.size() != 0 || dones - d0 != 1) begin
      fails++;
      $display("FAIL pause_idle got=busy%b left%0d dones%0d required=busy0 left0 dones1", busy, exp_q.size(), dones - d0);
    end
  endtask
  task automatic test_timeout;
    int n, b0;
    bit seen;
    n = 0; seen = 0; b0 = beats;
    start_burst(4'd2, 8'h55, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_err) break;
      if (req) n++;
    end
    tests++;
    if (timeout_err !== 1 || n != 15 || req !== 0 || busy !== 1) begin
      fails++;
      $display("FAIL timeout_pulse got=terr%b reqcycles%0d req%b busy%b required=terr1 reqcycles15 req0 busy1", timeout_err, n, req, busy);
    end
    @(negedge clk);
    tests++;
    if (busy !== 0 || timeout_err !== 0 || beats != b0) begin
      fails++;
      $display("FAIL timeout_idle got=busy%b terr%b beats%0d required=busy0 terr0 beats0", busy, timeout_err, beats - b0);
    end
  endtask
  task automatic test_ignored_start;
    int b0;
    @(posedge clk); #1 start = 1; len = 0; seed = 8'h77;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    tests++;
    if (req !== 0 || busy !== 0) begin fails++; $display("FAIL len0_ignored got=%b%b required=00", req, busy); end
    b0 = beats;
    start_burst(4'd2, 8'h30, 1);
    @(posedge clk); #1 start = 1; len = 4'd5; seed = 8'h99;
    @(posedge clk); #1 start = 0; len = 0; gnt = 1;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    tests++;
    if (done !== 1 || beats - b0 != 2) begin fails++; $display("FAIL busy_start_ignored got=done%b beats%0d required=done1 beats2", done, beats - b0); end
    @(posedge clk); #1 gnt = 0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    tests++;
    if (req !== 0 || busy !== 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL no_queued_burst got=req%b busy%b left%0d required=req0 busy0 left0", req, busy, exp_q.size());
    end
  endtask
  task automatic test_release_hold;
    start_burst(4'd1, 8'hF0, 1);
    gnt = 1;
    repeat (3) @(negedge clk);
    tests++;
    if (done !== 1 || req !== 0 || busy !== 1) begin fails++; $display("FAIL hold_done got=%b%b%b required=101", done, req, busy); end
    @(posedge clk); #1 start = 1; len = 4'd3; seed = 8'h00;
    @(negedge clk);
    tests++;
    if (busy !== 1 || req !== 0) begin fails++; $display("FAIL hold_release1 got=%b%b required=10", busy, req); end
    @(posedge clk); #1 start = 0; len = 0;
    @(negedge clk);
    tests++;
    if (busy !== 1 || req !== 0) begin fails++; $display("FAIL hold_release2 got=%b%b required=10", busy, req); end
    @(posedge clk); #1 gnt = 0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 0 || req !== 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL hold_start_ignored got=busy%b req%b left%0d required=busy0 req0 left0", busy, req, exp_q.size());
    end
  endtask
  task automatic test_rst_mid_xfer;
    start_burst(4'd5, 8'h40, 1);
    gnt = 1;
    repeat (3) @(negedge clk);
    #1 rst = 1;
    #1;
    tests++;
    if (req !== 0 || busy !== 0 || data_valid !== 0 || data_out !== 8'h00) begin
      fails++;
      $display("FAIL rst_async got=%b%b%b/%h required=000/00", req, busy, data_valid, data_out);
    end
    tests++;
    if (exp_q.size() != 3) begin fails++; $display("FAIL rst_beats_sent got=%0d required=2", 5 - exp_q.size()); end
    exp_q.delete();
    gnt = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    tests++;
    if (busy !== 0 || req !== 0) begin fails++; $display("FAIL rst_idle got=%b%b required=00", busy, req); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_pause;
    test_timeout;
    test_ignored_start;
    test_release_hold;
    test_rst_mid_xfer;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
